uart_tx_frame: RTL and testbench

Parametrised UART transmit framer, the successor to the fixed combinational parity generator. It serialises one G_WIDTH-bit word per frame, LSB first: start bit, data bits, an optional parity bit, then one or two stop bits. Parity mode, stop-bit count and bit period are selected at run time. It sits between the TX FIFO/register interface and the serial line pin.

---
 rtl/uart_tx_frame.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer.
// Sends start bit, G_WIDTH data bits LSB first, an optional parity bit and one or
// two stop bits. Bit period, parity mode and stop count are latched with each word.
module uart_tx_frame #(
  parameter int unsigned G_WIDTH     = 8,
  parameter int unsigned G_DIV_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [G_WIDTH-1:0]     i_tx_data,
  input  logic                   i_tx_valid,
  output logic                   o_tx_ready,
  input  logic [G_DIV_WIDTH-1:0] i_baud_div,
  input  logic [2:0]             i_parity_mode,
  input  logic                   i_two_stop,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned C_BW = (G_WIDTH > 1) ? $clog2(G_WIDTH) : 1;
  localparam logic [C_BW-1:0]        C_LAST_BIT = C_BW'(G_WIDTH - 1);
  localparam logic [G_DIV_WIDTH-1:0] C_DIV_ONE  = G_DIV_WIDTH'(1);
  localparam logic [G_DIV_WIDTH-1:0] C_DIV_TWO  = G_DIV_WIDTH'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 r_state;
  logic [G_DIV_WIDTH-1:0] r_baud_cnt;
  logic [G_DIV_WIDTH-1:0] r_div;
  logic [C_BW-1:0]        r_bit_cnt;
  logic [G_WIDTH-1:0]     r_shift;
  logic                   r_par_en;
  logic                   r_par_bit;
  logic                   r_two_stop;
  logic                   r_stop_idx;
  logic                   r_tx;
  logic                   r_tx_ready;
  logic                   r_done;

  logic                   w_accept;
  logic [G_DIV_WIDTH-1:0] w_div_eff;
  logic                   w_par_en;
  logic                   w_par_bit;
  logic                   w_bit_end;
  logic                   w_pre_end;
  logic                   w_div_is_one;
  logic                   w_last_stop;
  logic                   w_final_next;

  assign w_accept     = i_tx_valid & r_tx_ready;
  assign w_div_eff    = (i_baud_div == '0) ? C_DIV_ONE : i_baud_div;
  assign w_div_is_one = (r_div == C_DIV_ONE);
  assign w_bit_end    = (r_baud_cnt == (r_div - C_DIV_ONE));
  assign w_pre_end    = !w_div_is_one && (r_baud_cnt == (r_div - C_DIV_TWO));
  assign w_last_stop  = (r_stop_idx == r_two_stop);

  // Decode the parity mode and compute the parity bit of the word being offered
  always_comb begin
    w_par_en  = 1'b0;
    w_par_bit = 1'b0;
    case (i_parity_mode)
      3'b001: begin w_par_en = 1'b1; w_par_bit = ^i_tx_data;  end
      3'b010: begin w_par_en = 1'b1; w_par_bit = ~^i_tx_data; end
      3'b011: begin w_par_en = 1'b1; w_par_bit = 1'b1;        end
      3'b100: begin w_par_en = 1'b1; w_par_bit = 1'b0;        end
      default: begin w_par_en = 1'b0; w_par_bit = 1'b0;       end
    endcase
  end

  // Flag that the coming cycle is the final clock of the frame: done/ready are
  // raised one cycle early so a back-to-back word is accepted with no idle gap
  always_comb begin
    w_final_next = 1'b0;
    case (r_state)
      S_DATA:   w_final_next = w_bit_end && (r_bit_cnt == C_LAST_BIT) &&
                               !r_par_en && !r_two_stop && w_div_is_one;
      S_PARITY: w_final_next = w_bit_end && !r_two_stop && w_div_is_one;
      S_STOP:   w_final_next = w_last_stop ? w_pre_end : (w_bit_end && w_div_is_one);
      default:  w_final_next = 1'b0;
    endcase
  end

  // Framing FSM with baud counter, shift register and registered line/handshake outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_div      <= C_DIV_ONE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_final_next;
      if (w_final_next) begin
        r_tx_ready <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_START;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_idx <= 1'b0;
            r_div      <= w_div_eff;
            r_shift    <= i_tx_data;
            r_par_en   <= w_par_en;
            r_par_bit  <= w_par_bit;
            r_two_stop <= i_two_stop;
            r_tx       <= 1'b0;
            r_tx_ready <= 1'b0;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_state    <= S_DATA;
            r_tx       <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + C_DIV_ONE;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == C_LAST_BIT) begin
              if (r_par_en) begin
                r_state <= S_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state    <= S_STOP;
                r_stop_idx <= 1'b0;
                r_tx       <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= {1'b0, r_shift[G_WIDTH-1:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + C_DIV_ONE;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_state    <= S_STOP;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + C_DIV_ONE;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (w_last_stop) begin
              // Final clock of the frame: ready is already high, so chain the next word here
              if (w_accept) begin
                r_state    <= S_START;
                r_bit_cnt  <= '0;
                r_stop_idx <= 1'b0;
                r_div      <= w_div_eff;
                r_shift    <= i_tx_data;
                r_par_en   <= w_par_en;
                r_par_bit  <= w_par_bit;
                r_two_stop <= i_two_stop;
                r_tx       <= 1'b0;
                r_tx_ready <= 1'b0;
              end else begin
                r_state <= S_IDLE;
                r_tx    <= 1'b1;
              end
            end else begin
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + C_DIV_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx       = r_tx;
  assign o_tx_ready = r_tx_ready;
  assign o_busy     = ~r_tx_ready;
  assign o_done     = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: table-driven frames plus hand-written corner sequences.
module tb_uart_tx_frame;

  logic        clk;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] baud_div;
  logic [2:0]  parity_mode;
  logic        two_stop;
  logic        tx;
  logic        busy;
  logic        done;

  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [2:0]  mode;
    logic        two;
    int unsigned d_eff;
    logic        par_en;
    logic        par;
    int unsigned n_clk;
  } vec_t;

  vec_t vecs[9];

  uart_tx_frame #(.G_WIDTH(8), .G_DIV_WIDTH(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_tx_data    (tx_data),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .i_baud_div   (baud_div),
    .i_parity_mode(parity_mode),
    .i_two_stop   (two_stop),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int unsigned cyc, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  // Expected line level in cycle c (1-based, counted from the accept edge)
  function automatic logic exp_bit(input vec_t v, input int unsigned c);
    int unsigned idx;
    logic [7:0] d;
    d   = v.data;
    idx = (c - 1) / v.d_eff;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (v.par_en && idx == 9) return v.par;
    return 1'b1;
  endfunction

  task automatic wait_ready();
    int unsigned guard;
    guard = 0;
    @(negedge clk);
    while (!tx_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_frame", 0, tx_ready, 1'b1);
  endtask

  task automatic run_frame(input vec_t v, input bit perturb);
    wait_ready();
    tx_data     = v.data;
    baud_div    = v.div;
    parity_mode = v.mode;
    two_stop    = v.two;
    tx_valid    = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    for (int unsigned c = 1; c <= v.n_clk; c++) begin
      chk("tx_bit", c, tx, exp_bit(v, c));
      chk("done", c, done, (c == v.n_clk));
      chk("ready", c, tx_ready, (c == v.n_clk));
      chk("busy", c, busy, (c != v.n_clk));
      if (perturb && c == 14) begin
        baud_div    = 16'd7;
        parity_mode = 3'b010;
        two_stop    = 1'b1;
        tx_data     = ~v.data;
      end
      if (c < v.n_clk) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    chk("idle_tx", v.n_clk + 1, tx, 1'b1);
    chk("idle_done", v.n_clk + 1, done, 1'b0);
  endtask

  initial begin
    vec_t v1;
    vec_t v2;
    vec_t vr;

    n_checks = 0;
    n_fail   = 0;

    //          data   div    mode    two   D  pen  par  clocks
    vecs[0] = '{8'hA5, 16'd4, 3'b001, 1'b0, 4, 1'b1, 1'b0, 44};
    vecs[1] = '{8'hA5, 16'd4, 3'b010, 1'b0, 4, 1'b1, 1'b1, 44};
    vecs[2] = '{8'h00, 16'd4, 3'b011, 1'b0, 4, 1'b1, 1'b1, 44};
    vecs[3] = '{8'hFF, 16'd4, 3'b100, 1'b0, 4, 1'b1, 1'b0, 44};
    vecs[4] = '{8'h07, 16'd4, 3'b001, 1'b0, 4, 1'b1, 1'b1, 44};
    vecs[5] = '{8'h3C, 16'd3, 3'b000, 1'b1, 3, 1'b0, 1'b0, 33};
    vecs[6] = '{8'h3C, 16'd3, 3'b110, 1'b1, 3, 1'b0, 1'b0, 33};
    vecs[7] = '{8'h5A, 16'd0, 3'b000, 1'b0, 1, 1'b0, 1'b0, 10};
    vecs[8] = '{8'h81, 16'd1, 3'b010, 1'b1, 1, 1'b1, 1'b1, 12};

    rst         = 1'b1;
    tx_valid    = 1'b0;
    tx_data     = '0;
    baud_div    = 16'd4;
    parity_mode = 3'b000;
    two_stop    = 1'b0;

    #12;
    chk("rst_tx", 0, tx, 1'b1);
    chk("rst_ready", 0, tx_ready, 1'b1);
    chk("rst_busy", 0, busy, 1'b0);
    chk("rst_done", 0, done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_tx", 0, tx, 1'b1);
    chk("post_rst_ready", 0, tx_ready, 1'b1);

    // Table-driven frames
    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i], 1'b0);
    end

    // Inputs scrambled during DATA must not disturb the frame in flight
    run_frame(vecs[0], 1'b1);

    // Back-to-back frames with valid held high, D=2, even parity
    v1 = '{8'h11, 16'd2, 3'b001, 1'b0, 2, 1'b1, 1'b0, 22};
    v2 = '{8'h22, 16'd2, 3'b001, 1'b0, 2, 1'b1, 1'b0, 22};
    wait_ready();
    tx_data     = v1.data;
    baud_div    = v1.div;
    parity_mode = v1.mode;
    two_stop    = v1.two;
    tx_valid    = 1'b1;
    @(posedge clk);
    #1;
    for (int unsigned c = 1; c <= 44; c++) begin
      if (c <= 22) chk("b2b_tx1", c, tx, exp_bit(v1, c));
      else         chk("b2b_tx2", c, tx, exp_bit(v2, c - 22));
      chk("b2b_done", c, done, (c == 22 || c == 44));
      chk("b2b_ready", c, tx_ready, (c == 22 || c == 44));
      if (c == 1) tx_data = v2.data;
      if (c == 23) tx_valid = 1'b0;
      if (c < 44) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    chk("b2b_idle_tx", 45, tx, 1'b1);
    chk("b2b_idle_done", 45, done, 1'b0);

    // Asynchronous reset during data bit 3 (cycles 17..20 at D=4)
    vr = '{8'hA5, 16'd4, 3'b000, 1'b0, 4, 1'b0, 1'b0, 40};
    wait_ready();
    tx_data     = vr.data;
    baud_div    = vr.div;
    parity_mode = vr.mode;
    two_stop    = vr.two;
    tx_valid    = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    for (int unsigned c = 1; c <= 18; c++) begin
      chk("pre_rst_tx", c, tx, exp_bit(vr, c));
      if (c < 18) begin
        @(posedge clk);
        #1;
      end
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tx", 18, tx, 1'b1);
    chk("async_rst_ready", 18, tx_ready, 1'b1);
    chk("async_rst_busy", 18, busy, 1'b0);
    chk("async_rst_done", 18, done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      chk("aborted_no_done", c, done, 1'b0);
      chk("aborted_tx_idle", c, tx, 1'b1);
    end

    // Normal operation resumes after the abort
    run_frame(vecs[4], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
